sevseg_scan_sequencer: RTL

Scan sequencer for the eight-digit seven-segment display behind the system controller. It replaces the free-running divider/mux select with a state machine that visits only enabled digits. Each visit has a programmable dwell, an inter-digit blanking gap (anti-ghosting) and 4-bit PWM brightness. It drives anode enables and the selected 8-bit digit code into the existing seven-segment decoder; the system-controller register file supplies all its configuration.

---
 rtl/sevseg_pkg.sv | 19 +
 rtl/sevseg_next_digit.sv | 40 ++++
 rtl/sevseg_scan_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scan sequencer.
package sevseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam int N_DIGITS = 8;
  localparam logic [7:0] BLANK_CODE = 8'hFF;
  localparam logic [7:0] AN_OFF = 8'hFF;

  // Active-low one-cold anode pattern selecting a single digit.
  function automatic logic [N_DIGITS-1:0] an_select(input logic [2:0] idx);
    return ~(N_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/sevseg_next_digit.sv
// Rotating priority encoder: finds the first enabled digit strictly after
// cur, searching circularly so that cur itself is the last candidate.
module sevseg_next_digit
  import sevseg_pkg::*;
(
  input  logic [N_DIGITS-1:0] enables,
  input  logic [2:0]          cur,
  output logic [2:0]          nxt,
  output logic                wrap,
  output logic                none
);

  // rot[k] is the enable of the digit k+1 positions after cur.
  logic [N_DIGITS-1:0] rot;
  logic [2:0]          off;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_rot
      logic [2:0] pos;
      assign pos     = cur + 3'(gi + 1);
      assign rot[gi] = enables[pos];
    end
  endgenerate

  // Lowest set position in the rotated vector is the nearest successor.
  always_comb begin
    off = 3'd7;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = 3'(i);
      end
    end
  end

  assign nxt  = cur + off + 3'd1;
  assign wrap = (nxt <= cur);
  assign none = ~|enables;

endmodule

// File: rtl/sevseg_scan_sequencer.sv
// Scan sequencer for an eight-digit seven-segment display: visits enabled
// digits only, with a blanking gap, programmable dwell and 4-bit PWM.
module sevseg_scan_sequencer
  import sevseg_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int BLANK_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_DIGITS-1:0]   i_digit_en,
  input  logic [8*N_DIGITS-1:0] i_digits,
  input  logic [DWELL_W-1:0]    i_dwell,
  input  logic [BLANK_W-1:0]    i_blank,
  input  logic [3:0]            i_bright,
  input  logic                  i_freeze,
  output logic [N_DIGITS-1:0]   o_an,
  output logic [7:0]            o_digit_code,
  output logic [2:0]            o_digit_idx,
  output logic                  o_frame_done
);

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [BLANK_W-1:0] BLANK_ONE = BLANK_W'(1);

  state_t               state_reg, state_next;
  logic [2:0]           idx_reg, idx_next;
  logic [BLANK_W-1:0]   blank_reg, blank_next;
  logic [DWELL_W-1:0]   dwell_reg, dwell_next;
  logic [3:0]           phase_reg, phase_next;
  logic [7:0]           code_reg, code_next;
  logic [N_DIGITS-1:0]  an_reg, an_next;
  logic                 frame_reg, frame_next;

  logic [2:0]           search_cur;
  logic [2:0]           nxt_idx;
  logic                 nxt_wrap;
  logic                 no_digits;
  logic [DWELL_W-1:0]   dwell_eff;
  logic [BLANK_W-1:0]   blank_eff;

  // From IDLE, searching after digit 7 yields the lowest enabled digit.
  assign search_cur = (state_reg == IDLE) ? 3'd7 : idx_reg;

  // Zero-length periods are stretched to one cycle.
  assign dwell_eff = (i_dwell == '0) ? DWELL_ONE : i_dwell;
  assign blank_eff = (i_blank == '0) ? BLANK_ONE : i_blank;

  sevseg_next_digit u_next_digit (
    .enables (i_digit_en),
    .cur     (search_cur),
    .nxt     (nxt_idx),
    .wrap    (nxt_wrap),
    .none    (no_digits)
  );

  // State, counters and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= 3'd0;
      blank_reg <= '0;
      dwell_reg <= '0;
      phase_reg <= 4'd0;
      code_reg  <= BLANK_CODE;
      an_reg    <= AN_OFF;
      frame_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      blank_reg <= blank_next;
      dwell_reg <= dwell_next;
      phase_reg <= phase_next;
      code_reg  <= code_next;
      an_reg    <= an_next;
      frame_reg <= frame_next;
    end
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    logic [3:0] phase_inc;
    state_next = state_reg;
    idx_next   = idx_reg;
    blank_next = blank_reg;
    dwell_next = dwell_reg;
    phase_next = phase_reg;
    code_next  = code_reg;
    an_next    = AN_OFF;
    frame_next = 1'b0;
    phase_inc  = phase_reg + 4'd1;

    case (state_reg)
      IDLE: begin
        if (!no_digits) begin
          state_next = BLANK;
          idx_next   = nxt_idx;
          blank_next = BLANK_ONE;
        end
      end

      BLANK: begin
        if (blank_reg >= blank_eff) begin
          // Latch the code once so a register write cannot tear this digit.
          state_next = ON;
          code_next  = i_digits[{idx_reg, 3'b000} +: 8];
          dwell_next = DWELL_ONE;
          phase_next = 4'd0;
          // Phase 0 is always within the duty window.
          if (i_digit_en[idx_reg]) begin
            an_next = an_select(idx_reg);
          end
        end else begin
          blank_next = blank_reg + BLANK_ONE;
        end
      end

      ON: begin
        if (!i_freeze && (dwell_reg >= dwell_eff)) begin
          if (no_digits) begin
            state_next = IDLE;
            blank_next = '0;
            dwell_next = '0;
            phase_next = 4'd0;
          end else begin
            state_next = BLANK;
            idx_next   = nxt_idx;
            blank_next = BLANK_ONE;
            frame_next = nxt_wrap;
          end
        end else begin
          if (!i_freeze) begin
            dwell_next = dwell_reg + DWELL_ONE;
          end
          phase_next = phase_inc;
          // Live enable check lets software blank the current digit at once.
          if ((phase_inc <= i_bright) && i_digit_en[idx_reg]) begin
            an_next = an_select(idx_reg);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_an         = an_reg;
  assign o_digit_code = code_reg;
  assign o_digit_idx  = idx_reg;
  assign o_frame_done = frame_reg;

endmodule
